// File: rtl/leaf_user_pkg.sv
// Shared types for the leaf user-side transmitter: FSM state encoding and payload word.
package leaf_user_pkg;

  localparam int PAYLOAD_BITS_DEFAULT = 32;

  typedef logic [PAYLOAD_BITS_DEFAULT-1:0] payload_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/leaf_user_fifo.sv
// Synchronous first-word-fall-through FIFO; head_o shows the oldest entry, or zero when empty.
module leaf_user_fifo #(
  parameter int PAYLOAD_BITS = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_BITS    = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [PAYLOAD_BITS-1:0] data_i,
  output logic [PAYLOAD_BITS-1:0] head_o,
  output logic [ADDR_BITS:0]      count_o
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = FIFO_DEPTH[ADDR_BITS:0];

  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_BITS-1:0]    wrPtr_q, wrPtr_d;
  logic [ADDR_BITS-1:0]    rdPtr_q, rdPtr_d;
  logic [ADDR_BITS:0]      count_q, count_d;

  // Pointers wrap naturally at the power-of-two depth; simultaneous push and pop leave count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = wrPtr_q + 1'b1;
    if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  // Storage is never cleared, so an empty FIFO must mask stale contents.
  assign head_o  = (count_q != '0) ? mem_q[rdPtr_q] : '0;
  assign count_o = count_q;

  assert property (@(posedge clk_i) count_q <= FULL_COUNT);

endmodule

// File: rtl/leaf_user_tx.sv
// User-side transmitter for one leaf output port: buffers kernel words and hands them to leaf_interface.
// Optional macro LEAF_USER_TX_WORD_CNT_EN adds a tx_word_cnt output counting delivered words.
module leaf_user_tx
  import leaf_user_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_BITS    = 4
) (
  input  logic                    clk_user,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    drain,
  input  logic [PAYLOAD_BITS-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic                    vld_user2interface,
  input  logic                    ack_interface2user,
  output logic                    busy,
`ifdef LEAF_USER_TX_WORD_CNT_EN
  output logic [31:0]             tx_word_cnt,
`endif
  output logic [ADDR_BITS:0]      fifo_count
);

  localparam logic [ADDR_BITS:0] FULL_COUNT = FIFO_DEPTH[ADDR_BITS:0];

  state_e             state_q;
  logic               pushEn;
  logic               popEn;
  logic [ADDR_BITS:0] fifoCount;

  // Handshake qualifiers depend only on registered state, never on ack or s_valid.
  assign s_ready            = (state_q == RUN) && (fifoCount != FULL_COUNT);
  assign vld_user2interface = (state_q != IDLE) && (fifoCount != '0);
  assign busy               = (state_q != IDLE);
  assign pushEn             = s_valid && s_ready;
  assign popEn              = vld_user2interface && ack_interface2user;
  assign fifo_count         = fifoCount;

  always_ff @(posedge clk_user) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN:     if (drain) state_q <= DRAIN;
        DRAIN:   if (fifoCount == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  leaf_user_fifo #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .ADDR_BITS    (ADDR_BITS)
  ) u_fifo (
    .clk_i     (clk_user),
    .reset_n_i (reset_n),
    .push_i    (pushEn),
    .pop_i     (popEn),
    .data_i    (s_data),
    .head_o    (din_leaf_user2interface),
    .count_o   (fifoCount)
  );

`ifdef LEAF_USER_TX_WORD_CNT_EN
  logic [31:0] wordCnt_q;

  // Only an accepted start (from IDLE) restarts the count; no pops can coincide with it.
  always_ff @(posedge clk_user) begin
    if (!reset_n) begin
      wordCnt_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      wordCnt_q <= '0;
    end else if (popEn) begin
      wordCnt_q <= wordCnt_q + 32'd1;
    end
  end

  assign tx_word_cnt = wordCnt_q;
`endif

endmodule

// File: tb/tb_leaf_user_tx.sv
// Directed self-checking bench for leaf_user_tx; checks word count too when LEAF_USER_TX_WORD_CNT_EN is defined.
module tb_leaf_user_tx;
  import leaf_user_pkg::*;

  logic        clk_user = 1'b0;
  logic        reset_n;
  logic        start;
  logic        drain;
  payload_t    s_data;
  logic        s_valid;
  logic        s_ready;
  payload_t    din;
  logic        vld;
  logic        ack;
  logic        busy;
  logic [4:0]  fifo_count;
`ifdef LEAF_USER_TX_WORD_CNT_EN
  logic [31:0] tx_word_cnt;
`endif

  int assertions = 0;
  int failures   = 0;

  always #5 clk_user = ~clk_user;

  leaf_user_tx dut (
    .clk_user                (clk_user),
    .reset_n                 (reset_n),
    .start                   (start),
    .drain                   (drain),
    .s_data                  (s_data),
    .s_valid                 (s_valid),
    .s_ready                 (s_ready),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .busy                    (busy),
`ifdef LEAF_USER_TX_WORD_CNT_EN
    .tx_word_cnt             (tx_word_cnt),
`endif
    .fifo_count              (fifo_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus();
    @(posedge clk_user);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; drain = 1'b0;
    s_data = '0; s_valid = 1'b0; ack = 1'b0;

    // Reset held three cycles, then released with no start.
    repeat (3) applyStimulus();
    reset_n = 1'b1;
    applyStimulus();
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_vld", 32'(vld), 32'd0);
    checkOutput("rst_din", din, 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Basic stream with ack held high: each word is at the head one cycle after its push.
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("run_busy", 32'(busy), 32'd1);
    checkOutput("run_s_ready", 32'(s_ready), 32'd1);
    checkOutput("run_vld_empty", 32'(vld), 32'd0);
    ack = 1'b1;
    s_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      s_data = 32'(k);
      applyStimulus();
      checkOutput("stream_vld", 32'(vld), 32'd1);
      checkOutput("stream_din", din, 32'(k));
      checkOutput("stream_count", 32'(fifo_count), 32'd1);
    end
    s_valid = 1'b0;
    applyStimulus();
    checkOutput("stream_count_end", 32'(fifo_count), 32'd0);
    checkOutput("stream_vld_end", 32'(vld), 32'd0);
`ifdef LEAF_USER_TX_WORD_CNT_EN
    checkOutput("wcnt_stream", tx_word_cnt, 32'd5);
`endif

    // Backpressure: fill all 16 entries with ack low.
    ack = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = 32'hA0 + 32'(i);
      applyStimulus();
      checkOutput("fill_count", 32'(fifo_count), 32'(i + 1));
    end
    checkOutput("full_s_ready", 32'(s_ready), 32'd0);
    checkOutput("full_din", din, 32'hA0);
    checkOutput("full_vld", 32'(vld), 32'd1);

    // Release ack while the kernel keeps offering: the first cycle only pops, then push and pop coexist.
    ack = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      s_data = (j == 1) ? 32'hB0 : 32'hB0 + 32'(j - 2);
      applyStimulus();
      checkOutput("flow_din", din, 32'hA0 + 32'(j));
      checkOutput("flow_count", 32'(fifo_count), 32'd15);
    end
    s_valid = 1'b0;
    applyStimulus();
    checkOutput("flow_last_a", din, 32'hB0);
    for (int m = 0; m < 14; m++) begin
      checkOutput("empty_din", din, 32'hB0 + 32'(m));
      applyStimulus();
    end
    checkOutput("empty_count", 32'(fifo_count), 32'd0);
    checkOutput("empty_din_zero", din, 32'd0);
`ifdef LEAF_USER_TX_WORD_CNT_EN
    checkOutput("wcnt_flow", tx_word_cnt, 32'd35);
`endif

    // Drain: three buffered words plus one pushed in the drain cycle; later offers are refused.
    ack = 1'b0;
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 32'hC0 + 32'(i);
      applyStimulus();
    end
    checkOutput("pre_drain_count", 32'(fifo_count), 32'd3);
    drain = 1'b1;
    s_data = 32'hC4;
    applyStimulus();
    drain = 1'b0;
    checkOutput("drain_count", 32'(fifo_count), 32'd4);
    checkOutput("drain_s_ready", 32'(s_ready), 32'd0);
    checkOutput("drain_busy", 32'(busy), 32'd1);
    s_data = 32'hEE;
    applyStimulus();
    checkOutput("drain_ignore", 32'(fifo_count), 32'd4);
    ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_din", din, 32'hC0 + 32'(i));
      applyStimulus();
    end
    s_valid = 1'b0;
    checkOutput("drain_empty_count", 32'(fifo_count), 32'd0);
    checkOutput("drain_still_busy", 32'(busy), 32'd1);
    applyStimulus();
    checkOutput("drain_idle", 32'(busy), 32'd0);
`ifdef LEAF_USER_TX_WORD_CNT_EN
    checkOutput("wcnt_drain", tx_word_cnt, 32'd39);
`endif

    // start and drain together in IDLE go to RUN; a drain on an empty FIFO spends one cycle in DRAIN.
    start = 1'b1;
    drain = 1'b1;
    applyStimulus();
    start = 1'b0;
    drain = 1'b0;
    checkOutput("both_idle_run", 32'(s_ready), 32'd1);
    checkOutput("both_idle_busy", 32'(busy), 32'd1);
`ifdef LEAF_USER_TX_WORD_CNT_EN
    checkOutput("wcnt_cleared", tx_word_cnt, 32'd0);
`endif
    drain = 1'b1;
    applyStimulus();
    drain = 1'b0;
    checkOutput("empty_drain_busy", 32'(busy), 32'd1);
    checkOutput("empty_drain_s_ready", 32'(s_ready), 32'd0);
    applyStimulus();
    checkOutput("empty_drain_idle", 32'(busy), 32'd0);

    // Reset with eight words buffered discards them.
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    ack = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 32'h10 + 32'(i);
      applyStimulus();
    end
    s_valid = 1'b0;
    checkOutput("mid_count", 32'(fifo_count), 32'd8);
    reset_n = 1'b0;
    applyStimulus();
    reset_n = 1'b1;
    checkOutput("mid_rst_vld", 32'(vld), 32'd0);
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_din", din, 32'd0);

    // Fresh start after reset; then start and drain together in RUN go to DRAIN.
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    ack = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h55;
    applyStimulus();
    s_valid = 1'b0;
    checkOutput("fresh_vld", 32'(vld), 32'd1);
    checkOutput("fresh_din", din, 32'h55);
    start = 1'b1;
    drain = 1'b1;
    applyStimulus();
    start = 1'b0;
    drain = 1'b0;
    checkOutput("both_run_busy", 32'(busy), 32'd1);
    checkOutput("both_run_s_ready", 32'(s_ready), 32'd0);
    checkOutput("both_run_count", 32'(fifo_count), 32'd0);
    applyStimulus();
    checkOutput("both_run_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
